triumph_hazard_ctrl: RTL and testbench
======================================

// Module: triumph_hazard_ctrl
// PURPOSE
//  Issue controller between ID and EX: scoreboards in-flight register writes and stalls ID on RAW hazards
//  (no forwarding network exists). Sequences fence drains and flushes. Emits registered EX issue
//  valid/rd info. Retires entries on WB commit.
// PARAMETERS
//  NREG    32  architectural registers tracked (x0 never tracked)
//  ADDR_W  5   register address width, = clog2(NREG)
//  CNT_W   2   per-register pending-write counter width; max in-flight writes/reg = 2**CNT_W-1
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_ni         in   1       synchronous reset, active low
//  id_valid_i     in   1       ID holds a decoded instruction
//  id_ready_o     out  1       issue accepted this cycle (combinational)
//  id_rs1_addr_i  in   ADDR_W  source 1;  id_rs1_used_i in 1: rs1 read
//  id_rs2_addr_i  in   ADDR_W  source 2;  id_rs2_used_i in 1: rs2 read
//  id_rd_addr_i   in   ADDR_W  destination; id_rd_we_i in 1: writes rd
//  id_fence_i     in   1       instruction requires all prior writes retired
//  flush_i        in   1       squash all in-flight work
//  wb_commit_i    in   1       WB writes regfile this cycle
//  wb_rd_addr_i   in   ADDR_W  register written by WB
//  ex_valid_o     out  1       registered: instruction entering EX
//  ex_rd_addr_o   out  ADDR_W  registered rd of issued instruction
//  ex_rd_we_o     out  1       registered rd write enable
//  busy_o         out  1       any counter non-zero
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): counters=0, state=RUN, ex_valid_o=0, ex_rd_addr_o=0, ex_rd_we_o=0.
//  Hazard (uses registered counters): (rs1_used & cnt[rs1]!=0 & rs1!=0) | same for rs2
//   | (rd_we & rd!=0 & cnt[rd]==max) | (id_fence_i & busy_o).
//  id_ready_o = id_valid_i & state!=DRAIN & ~hazard & ~flush_i. Issue = id_ready_o.
//  Latency: issue in cycle N -> ex_valid_o/ex_rd_* in N+1; ex_valid_o=0 when no issue.
//  Counters: +1 on issue with rd_we & rd!=0; -1 on wb_commit_i & wb_rd_addr_i!=0; both on same reg
//   -> unchanged. Commit on cnt==0 is ignored (no underflow). Reader unblocks cycle after commit.
//  FSM: RUN   -> STALL on id_valid_i & hazard & ~id_fence_i; -> DRAIN on id_valid_i & id_fence_i & busy_o.
//       STALL -> RUN when hazard clears (issue happens in that cycle from STALL).
//       DRAIN -> RUN when busy_o=0; fence issues the following cycle.
//  flush_i: highest priority; next cycle all counters=0, state=RUN, ex_valid_o=0; same-cycle commit
//   ignored. Downstream must not commit flushed instructions.
//  Reset mid-stall/drain returns to RUN with empty scoreboard; no issue in reset cycle.
// CONFIGURATION
//  TRIUMPH_HAZ_PERF_EN defined: adds out 32-bit stall_cnt_o, +1 each cycle id_valid_i & ~id_ready_o
//   & ~flush_i, wraps at 2**32, reset 0, not cleared by flush.
//  Undefined: port and counter absent. Other behaviour identical.
// STRUCTURE
//  FSM state encodings HAZ_RUN/HAZ_STALL/HAZ_DRAIN go in triumph_riscv_defines.v.
//  Sub-module triumph_scoreboard: NREG counter array, inc/dec ports, per-reg nonzero/full flags, busy.
//  Top level: hazard logic, FSM, EX output registers, optional perf counter.
// TESTING
//  1 Issue add x3 (rd_we); next cycle read x3 -> id_ready_o=0; commit x3 at N+3 -> ready at N+4.
//  2 Reader rs1=x0 after write to x0 -> no stall; counter[0] stays 0, busy_o=0.
//  3 CNT_W=2: three issues writing x5, fourth writer -> stall until one commit of x5.
//  4 Fence with 2 writes pending -> DRAIN; after both commits busy_o=0, RUN, fence issues next cycle.
//  5 Issue x7 and commit x7 same cycle with cnt[x7]=1 -> cnt stays 1; flush -> busy_o=0 next cycle.
//  6 PERF_EN: 4-cycle RAW stall -> stall_cnt_o=4; reset pulse mid-stall -> 0, state RUN.

Source files
------------

// File: rtl/triumph_hazard_ctrl_pkg.sv
// Shared types and default sizing for the triumph ID/EX issue controller.
// Holds the HAZ_RUN / HAZ_STALL / HAZ_DRAIN issue-FSM state encodings.
package triumph_hazard_ctrl_pkg;

   localparam int NREG_DEF   = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int CNT_W_DEF  = 2;

   typedef enum logic [1:0] {
      HAZ_RUN   = 2'd0,
      HAZ_STALL = 2'd1,
      HAZ_DRAIN = 2'd2
   } haz_state_e;

endpackage

// File: rtl/triumph_scoreboard.sv
// Per-register pending-write counters; x0 is never tracked.
// Exposes nonzero/full flags per register plus an aggregate busy flag.
module triumph_scoreboard
   import triumph_hazard_ctrl_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              inc_i,
   input  logic [ADDR_W-1:0] inc_addr_i,
   input  logic              dec_i,
   input  logic [ADDR_W-1:0] dec_addr_i,
   output logic [NREG-1:0]   nonzero_o,
   output logic [NREG-1:0]   full_o,
   output logic              busy_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   assign nonzero_o[0] = 1'b0;
   assign full_o[0]    = 1'b0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         logic [CNT_W-1:0] cnt_reg;
         logic             inc_hit;
         logic             dec_hit;

         assign inc_hit = inc_i & (inc_addr_i == ADDR_W'(gi));
         // A commit against an empty counter is dropped so it cannot underflow.
         assign dec_hit = dec_i & (dec_addr_i == ADDR_W'(gi)) & (cnt_reg != '0);

         always_ff @(posedge clk_i) begin
            if (!rst_ni || clr_i) begin
               cnt_reg <= '0;
            end else if (inc_hit && !dec_hit) begin
               cnt_reg <= cnt_reg + 1'b1;
            end else if (dec_hit && !inc_hit) begin
               cnt_reg <= cnt_reg - 1'b1;
            end
         end

         assign nonzero_o[gi] = (cnt_reg != '0);
         assign full_o[gi]    = (cnt_reg == CNT_MAX);
      end
   endgenerate

   assign busy_o = |nonzero_o;

endmodule

// File: rtl/triumph_hazard_ctrl.sv
// ID->EX issue controller: RAW/WAW-capacity stalls, fence drain, flush, registered EX issue info.
// Optional TRIUMPH_HAZ_PERF_EN adds a 32-bit stall_cnt_o performance counter.
module triumph_hazard_ctrl
   import triumph_hazard_ctrl_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              id_valid_i,
   output logic              id_ready_o,
   input  logic [ADDR_W-1:0] id_rs1_addr_i,
   input  logic              id_rs1_used_i,
   input  logic [ADDR_W-1:0] id_rs2_addr_i,
   input  logic              id_rs2_used_i,
   input  logic [ADDR_W-1:0] id_rd_addr_i,
   input  logic              id_rd_we_i,
   input  logic              id_fence_i,
   input  logic              flush_i,
   input  logic              wb_commit_i,
   input  logic [ADDR_W-1:0] wb_rd_addr_i,
   output logic              ex_valid_o,
   output logic [ADDR_W-1:0] ex_rd_addr_o,
   output logic              ex_rd_we_o,
`ifdef TRIUMPH_HAZ_PERF_EN
   output logic [31:0]       stall_cnt_o,
`endif
   output logic              busy_o
);

   haz_state_e        state_reg, state_next;
   logic [NREG-1:0]   nonzero;
   logic [NREG-1:0]   full;
   logic              hazard;
   logic              issue;
   logic              ex_valid_reg;
   logic [ADDR_W-1:0] ex_rd_addr_reg;
   logic              ex_rd_we_reg;

   triumph_scoreboard #(
      .NREG   (NREG),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_scoreboard (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (flush_i),
      .inc_i      (issue & id_rd_we_i & (id_rd_addr_i != '0)),
      .inc_addr_i (id_rd_addr_i),
      .dec_i      (wb_commit_i & (wb_rd_addr_i != '0)),
      .dec_addr_i (wb_rd_addr_i),
      .nonzero_o  (nonzero),
      .full_o     (full),
      .busy_o     (busy_o)
   );

   // No forwarding: any pending write to a source blocks the reader.
   assign hazard = (id_rs1_used_i & (id_rs1_addr_i != '0) & nonzero[id_rs1_addr_i])
                 | (id_rs2_used_i & (id_rs2_addr_i != '0) & nonzero[id_rs2_addr_i])
                 | (id_rd_we_i & (id_rd_addr_i != '0) & full[id_rd_addr_i])
                 | (id_fence_i & busy_o);

   assign id_ready_o = rst_ni & id_valid_i & (state_reg != HAZ_DRAIN) & ~hazard & ~flush_i;
   assign issue      = id_ready_o;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HAZ_RUN: begin
            if (id_valid_i && id_fence_i && busy_o) begin
               state_next = HAZ_DRAIN;
            end else if (id_valid_i && hazard) begin
               state_next = HAZ_STALL;
            end
         end
         HAZ_STALL: begin
            if (!id_valid_i || !hazard) begin
               state_next = HAZ_RUN;
            end
         end
         HAZ_DRAIN: begin
            if (!busy_o) begin
               state_next = HAZ_RUN;
            end
         end
         default: state_next = HAZ_RUN;
      endcase
      if (flush_i) begin
         state_next = HAZ_RUN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg      <= HAZ_RUN;
         ex_valid_reg   <= 1'b0;
         ex_rd_addr_reg <= '0;
         ex_rd_we_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ex_valid_reg   <= issue;
         ex_rd_addr_reg <= issue ? id_rd_addr_i : '0;
         ex_rd_we_reg   <= issue & id_rd_we_i;
      end
   end

   assign ex_valid_o   = ex_valid_reg;
   assign ex_rd_addr_o = ex_rd_addr_reg;
   assign ex_rd_we_o   = ex_rd_we_reg;

`ifdef TRIUMPH_HAZ_PERF_EN
   logic [31:0] stall_cnt_reg;

   // Survives flush on purpose; only reset clears it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt_reg <= '0;
      end else if (id_valid_i && !id_ready_o && !flush_i) begin
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_triumph_hazard_ctrl.sv
// Directed table-driven bench for triumph_hazard_ctrl plus hand sequences for stall/reset corners.
// Define TRIUMPH_HAZ_PERF_EN to also check the stall counter.
module tb_triumph_hazard_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       id_valid_i;
   logic       id_ready_o;
   logic [4:0] id_rs1_addr_i;
   logic       id_rs1_used_i;
   logic [4:0] id_rs2_addr_i;
   logic       id_rs2_used_i;
   logic [4:0] id_rd_addr_i;
   logic       id_rd_we_i;
   logic       id_fence_i;
   logic       flush_i;
   logic       wb_commit_i;
   logic [4:0] wb_rd_addr_i;
   logic       ex_valid_o;
   logic [4:0] ex_rd_addr_o;
   logic       ex_rd_we_o;
   logic       busy_o;
`ifdef TRIUMPH_HAZ_PERF_EN
   logic [31:0] stall_cnt_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   triumph_hazard_ctrl dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .id_valid_i    (id_valid_i),
      .id_ready_o    (id_ready_o),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs1_used_i (id_rs1_used_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rs2_used_i (id_rs2_used_i),
      .id_rd_addr_i  (id_rd_addr_i),
      .id_rd_we_i    (id_rd_we_i),
      .id_fence_i    (id_fence_i),
      .flush_i       (flush_i),
      .wb_commit_i   (wb_commit_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .ex_valid_o    (ex_valid_o),
      .ex_rd_addr_o  (ex_rd_addr_o),
      .ex_rd_we_o    (ex_rd_we_o),
`ifdef TRIUMPH_HAZ_PERF_EN
      .stall_cnt_o   (stall_cnt_o),
`endif
      .busy_o        (busy_o)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       we;
      logic       fence;
      logic       flush;
      logic       commit;
      logic [4:0] wbrd;
      logic       exp_rdy;
      logic       exp_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int v, int rs1, int u1, int rs2, int u2, int rd, int we,
                               int fence, int flush, int commit, int wbrd, int rdy, int busy);
      vec_t r;
      r.v        = v[0];
      r.rs1      = rs1[4:0];
      r.u1       = u1[0];
      r.rs2      = rs2[4:0];
      r.u2       = u2[0];
      r.rd       = rd[4:0];
      r.we       = we[0];
      r.fence    = fence[0];
      r.flush    = flush[0];
      r.commit   = commit[0];
      r.wbrd     = wbrd[4:0];
      r.exp_rdy  = rdy[0];
      r.exp_busy = busy[0];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t r);
      id_valid_i    = r.v;
      id_rs1_addr_i = r.rs1;
      id_rs1_used_i = r.u1;
      id_rs2_addr_i = r.rs2;
      id_rs2_used_i = r.u2;
      id_rd_addr_i  = r.rd;
      id_rd_we_i    = r.we;
      id_fence_i    = r.fence;
      flush_i       = r.flush;
      wb_commit_i   = r.commit;
      wb_rd_addr_i  = r.wbrd;
   endtask

   // Starts and ends on a falling edge: comb outputs checked before the rising edge,
   // registered EX outputs checked just after it.
   task automatic step(input string tag, input vec_t r);
      apply(r);
      #4;
      chk($sformatf("%s id_ready", tag), 32'(id_ready_o), 32'(r.exp_rdy));
      chk($sformatf("%s busy", tag), 32'(busy_o), 32'(r.exp_busy));
      @(posedge clk_i);
      #1;
      chk($sformatf("%s ex_valid", tag), 32'(ex_valid_o), 32'(r.exp_rdy));
      if (r.exp_rdy) begin
         chk($sformatf("%s ex_rd_addr", tag), 32'(ex_rd_addr_o), 32'(r.rd));
         chk($sformatf("%s ex_rd_we", tag), 32'(ex_rd_we_o), 32'(r.we));
      end
      $display("%s: valid=%0b rs1=%0d rd=%0d fence=%0b flush=%0b commit=%0b/%0d -> ready=%0b busy=%0b ex_valid=%0b",
               tag, r.v, r.rs1, r.rd, r.fence, r.flush, r.commit, r.wbrd, id_ready_o, busy_o, ex_valid_o);
      @(negedge clk_i);
   endtask

   task automatic check_reset_state(input string tag);
      chk($sformatf("%s ex_valid", tag), 32'(ex_valid_o), 32'd0);
      chk($sformatf("%s ex_rd_addr", tag), 32'(ex_rd_addr_o), 32'd0);
      chk($sformatf("%s ex_rd_we", tag), 32'(ex_rd_we_o), 32'd0);
      chk($sformatf("%s busy", tag), 32'(busy_o), 32'd0);
`ifdef TRIUMPH_HAZ_PERF_EN
      chk($sformatf("%s stall_cnt", tag), stall_cnt_o, 32'd0);
`endif
   endtask

   initial begin
      apply(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_state("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 4-cycle RAW stall on x11, then commit releases the reader.
      step("perf issue x11", mk(1,0,0,0,0,11,1,0,0,0,0,1,0));
      step("perf stall1", mk(1,11,1,0,0,0,0,0,0,0,0,0,1));
      step("perf stall2", mk(1,11,1,0,0,0,0,0,0,0,0,0,1));
      step("perf stall3", mk(1,11,1,0,0,0,0,0,0,0,0,0,1));
      step("perf stall4", mk(1,11,1,0,0,0,0,0,0,1,11,0,1));
`ifdef TRIUMPH_HAZ_PERF_EN
      chk("perf stall_cnt after 4", stall_cnt_o, 32'd4);
`endif
      step("perf release", mk(1,11,1,0,0,0,0,0,0,0,0,1,0));

      // Reset while a reader of x12 is stalled.
      step("mid issue x12", mk(1,0,0,0,0,12,1,0,0,0,0,1,0));
      step("mid stall1", mk(1,12,1,0,0,0,0,0,0,0,0,0,1));
      step("mid stall2", mk(1,12,1,0,0,0,0,0,0,0,0,0,1));
      rst_ni = 1'b0;
      #4;
      chk("mid reset-cycle id_ready", 32'(id_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      check_reset_state("mid after reset");
      $display("mid reset: ex_valid=%0b busy=%0b", ex_valid_o, busy_o);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step("mid reader after reset", mk(1,12,1,0,0,0,0,0,0,0,0,1,0));

      // mk(v, rs1,u1, rs2,u2, rd,we, fence, flush, commit,wbrd, exp_ready, exp_busy)
      tbl.push_back(mk(1,1,1,2,1,3,1,0,0,0,0,1,0));   // issue add x3
      tbl.push_back(mk(1,3,1,0,0,4,1,0,0,0,0,0,1));   // RAW on x3
      tbl.push_back(mk(1,3,1,0,0,4,1,0,0,0,0,0,1));
      tbl.push_back(mk(1,3,1,0,0,4,1,0,0,1,3,0,1));   // commit x3 at N+3
      tbl.push_back(mk(1,3,1,0,0,4,1,0,0,0,0,1,0));   // ready at N+4
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,4,0,1));   // retire x4
      tbl.push_back(mk(1,0,1,0,0,0,1,0,0,0,0,1,0));   // write x0
      tbl.push_back(mk(1,0,1,0,1,0,0,0,0,0,0,1,0));   // read x0: no stall, not busy
      tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,1,0));   // x5 writer 1
      tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,1,1));   // x5 writer 2
      tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,1,1));   // x5 writer 3
      tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,0,1));   // 4th writer blocked (counter full)
      tbl.push_back(mk(1,0,0,0,0,5,1,0,0,1,5,0,1));   // commit x5
      tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0,0,1,1));   // 4th writer issues
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,5,0,1));   // x5 down to 2
      tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0,0,1));   // fence -> DRAIN
      tbl.push_back(mk(1,0,0,0,0,0,0,1,0,1,5,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0,1,0,1,5,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0,0,0));   // drained, still in DRAIN
      tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0,0,1,0));   // fence issues
      tbl.push_back(mk(1,0,0,0,0,7,1,0,0,0,0,1,0));   // x7 cnt -> 1
      tbl.push_back(mk(1,0,0,0,0,7,1,0,0,1,7,1,1));   // issue+commit x7: stays 1
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,0,0,8,1,0,1,1,7,0,1));   // flush wins
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));   // scoreboard empty
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,9,0,0));   // commit on empty x9
      tbl.push_back(mk(1,9,1,0,0,0,0,0,0,0,0,1,0));   // no underflow: x9 readable

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("row%0d", i), tbl[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
